sr_cmd_gen: RTL and testbench
=============================

# sr_cmd_gen

Front-end command generator for the edge-triggered SR flip-flop stage. Takes two raw, asynchronous, bouncy button/level inputs and turns them into clean, single-cycle `s` and `r` command pulses on `cp`. Each raw input is synchronised and debounced, and only its rising edge produces a command. When set and reset qualify in the same cycle, the block emits a combined toggle command (`s=r=1`) or suppresses both, as selected at compile time.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles required before a level change is accepted; legal range 1 to 2^CNT_W−1.
- `CNT_W`, default 8: width of each debounce counter.
- `cp`, input, 1: clock; all state changes on its rising edge.
- `rst`, input, 1: reset, asynchronous, active-low; clears all state immediately.
- `btn_set`, input, 1: raw set request; asynchronous and may bounce.
- `btn_reset`, input, 1: raw reset request; asynchronous and may bounce.
- `s`, output, 1: registered set command pulse, one cycle wide; feeds SR flip-flop `s`.
- `r`, output, 1: registered reset command pulse, one cycle wide; feeds SR flip-flop `r`.
- `cmd_cnt`, output, 8: count of emitted commands (s, r or toggle each count 1); wraps 255→0.

## Operation
- Each raw input passes through a two-flop synchroniser (`sync1`, `sync2`), both reset to 0.
- Each channel has a debounce FSM driven by `sync2`, with a counter `cnt` of width CNT_W:
  - IDLE (accepted level 0): if `sync2`=1, go to RISE_WAIT with `cnt`=1.
  - RISE_WAIT: if `sync2`=0, return to IDLE with `cnt`=0. Otherwise, if `cnt`==DEBOUNCE_CYCLES, go to HIGH and raise a one-cycle `edge` strobe. Otherwise increment `cnt`.
  - HIGH (accepted level 1): if `sync2`=0, go to FALL_WAIT with `cnt`=1.
  - FALL_WAIT: if `sync2`=1, return to HIGH. If `cnt`==DEBOUNCE_CYCLES, go to IDLE. Otherwise increment `cnt`. No strobe is produced on falling edges.
- Output register, updated every cycle from the two channel strobes `es` (set) and `er` (reset):
  - `es` only: `s`=1, `r`=0.
  - `er` only: `s`=0, `r`=1.
  - Neither: `s`=0, `r`=0.
  - Both: see Configuration.
- `cmd_cnt` increments by 1 in every cycle where `s` or `r` is registered high.
- Holding a button never repeats the command. A new command requires release, a debounced low, then a new press.
- Glitches shorter than DEBOUNCE_CYCLES cycles at `sync2` produce no command.

## Timing
- Reset values: `s`=0, `r`=0, `cmd_cnt`=0, all FSMs in IDLE, all `cnt`=0, all synchronisers 0. All take effect immediately on `rst` falling, with no clock required.
- Latency: the raw input rises before edge 0 and is held. `sync2` is high after edge 1. The strobe is generated at edge DEBOUNCE_CYCLES+1. `s` (or `r`) is high for exactly the cycle between edges DEBOUNCE_CYCLES+2 and DEBOUNCE_CYCLES+3. With the default of 4, that is edges 6 to 7.
- A button already held high when `rst` deasserts is treated as a fresh press and yields one command after the latency above.
- Reset asserted mid-debounce or during an output pulse aborts everything: no pulse is emitted, and no partial count is kept.
- The two channels are fully independent. Simultaneity is judged only at strobe level, in the same cycle.

## Configuration
- `SR_CMD_TOGGLE_EN` defined: when both strobes fire in the same cycle, the block outputs `s`=1, `r`=1 for one cycle (the toggle command). `cmd_cnt` increments by 1.
- `SR_CMD_TOGGLE_EN` undefined: when both strobes fire in the same cycle, the block outputs `s`=0, `r`=0. Both requests are dropped, and `cmd_cnt` does not change. The block can then never issue `s=r=1`.

## Structure
- Shared include `sr_cmd_defs.vh` holds:
  - FSM state encodings: IDLE=2'd0, RISE_WAIT=2'd1, HIGH=2'd2, FALL_WAIT=2'd3.
  - Default DEBOUNCE_CYCLES and CNT_W values.
- Sub-module `debounce_ch` contains the synchroniser, FSM and counter, and outputs `edge`. It is instantiated twice, once per channel.
- The top level holds the output register, the combine logic and `cmd_cnt`.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Reset check: assert `rst`=0 asynchronously mid-cycle → `s`=`r`=0 and `cmd_cnt`=0 immediately.
- Clean set press: `btn_set` rises before edge 0 and is held for 20 cycles → `s`=1 only between edges 6 and 7, `r`=0 throughout, `cmd_cnt`=1.
- Bounce rejection: `btn_reset` pulses high for 3 cycles, low for 2, high for 3 → no `r` pulse. It is then held high → exactly one `r` pulse, 6 cycles after the final rise.
- Simultaneous press: both buttons rise before the same edge and are held.
  - With `SR_CMD_TOGGLE_EN`: `s`=`r`=1 for one cycle, `cmd_cnt`+1.
  - Without it: no pulse and no count change.
- Reset mid-debounce: `btn_set` held, `rst` pulsed low at edge 3, button still held → no pulse before reset; one `s` pulse 6 cycles after `rst` deasserts.
- Counter wrap: 256 isolated set presses, each fully released between presses → `cmd_cnt` returns to 0.

Source files
------------

// File: rtl/sr_cmd_gen_pkg.sv
// sr_cmd_gen_pkg: debounce FSM state encoding and default parameters shared by the command generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sr_cmd_gen_pkg;

  // Debounce channel states; accepted level is 0 in IDLE/RISE_WAIT, 1 in HIGH/FALL_WAIT
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RISE_WAIT = 2'd1,
    HIGH      = 2'd2,
    FALL_WAIT = 2'd3
  } db_state_e;

  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int CNT_W_DEF           = 8;

endpackage

// File: rtl/sr_cmd_gen_debounce_ch.sv
// debounce_ch: two-flop synchroniser plus debounce FSM; one-cycle strobe on an accepted rising level.
// Latency: strobe is high in the cycle after edge DEBOUNCE_CYCLES+1 (counting the edge that first samples the raw input as edge 0).
// Backpressure: none; the raw input is free-running and the strobe is never held.
module debounce_ch
  import sr_cmd_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic edge_o
);

  localparam logic [CNT_W-1:0] DB_LIM = CNT_W'(DEBOUNCE_CYCLES);

  logic             sync1_q;
  logic             sync2_q;
  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Bring the asynchronous raw level into the clock domain
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // FSM state and stability counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: a level change is accepted only after it stays stable for DEBOUNCE_CYCLES more samples
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (sync2_q) begin
          state_d = RISE_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      RISE_WAIT: begin
        if (!sync2_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LIM) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HIGH: begin
        if (!sync2_q) begin
          state_d = FALL_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      FALL_WAIT: begin
        if (sync2_q) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else if (cnt_q == DB_LIM) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Strobe in the cycle whose closing edge accepts the new high level; falling edges stay silent
  always_comb begin
    edge_o = 1'b0;
    if (state_q == RISE_WAIT && sync2_q && cnt_q == DB_LIM) begin
      edge_o = 1'b1;
    end
  end

endmodule

// File: rtl/sr_cmd_gen.sv
// sr_cmd_gen: turns two bouncy raw buttons into clean single-cycle s/r commands for the SR flip-flop stage.
// Latency: s/r high between edges DEBOUNCE_CYCLES+2 and +3 after the raw rise; SR_CMD_TOGGLE_EN selects s=r=1 on coincident strobes (else both dropped).
// Backpressure: none; commands are fire-and-forget pulses, cmd_cnt wraps at 255.
module sr_cmd_gen
  import sr_cmd_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic       cp,
  input  logic       rst,
  input  logic       btn_set,
  input  logic       btn_reset,
  output logic       s,
  output logic       r,
  output logic [7:0] cmd_cnt
);

  logic       es;
  logic       er;
  logic       s_q, s_d;
  logic       r_q, r_d;
  logic [7:0] cmd_cnt_q, cmd_cnt_d;

  debounce_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_set_ch (
    .clk_i (cp),
    .rst_ni(rst),
    .raw_i (btn_set),
    .edge_o(es)
  );

  debounce_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_reset_ch (
    .clk_i (cp),
    .rst_ni(rst),
    .raw_i (btn_reset),
    .edge_o(er)
  );

  // Combine the strobes; coincident set and reset either toggle or cancel each other
  always_comb begin
    s_d = es & ~er;
    r_d = er & ~es;
`ifdef SR_CMD_TOGGLE_EN
    if (es && er) begin
      s_d = 1'b1;
      r_d = 1'b1;
    end
`endif
    cmd_cnt_d = cmd_cnt_q + {7'd0, (s_d | r_d)};
  end

  // Output pulse register and command counter, updated together
  always_ff @(posedge cp or negedge rst) begin
    if (!rst) begin
      s_q       <= 1'b0;
      r_q       <= 1'b0;
      cmd_cnt_q <= 8'd0;
    end else begin
      s_q       <= s_d;
      r_q       <= r_d;
      cmd_cnt_q <= cmd_cnt_d;
    end
  end

  assign s       = s_q;
  assign r       = r_q;
  assign cmd_cnt = cmd_cnt_q;

endmodule

// File: tb/tb_sr_cmd_gen.sv
// tb_sr_cmd_gen: directed and random button stimulus for sr_cmd_gen against a run-length reference model.
// Latency: model predicts s/r/cmd_cnt after every rising edge of cp.
// Backpressure: n/a.
module tb_sr_cmd_gen;

  localparam int DB = 4;

  logic       cp = 1'b0;
  logic       rst;
  logic       btn_set;
  logic       btn_reset;
  logic       s;
  logic       r;
  logic [7:0] cmd_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: two-stage sample delay, accepted level, and length of the run disagreeing with it
  bit m_sy1 [2];
  bit m_sy2 [2];
  bit m_acc [2];
  int m_run [2];
  bit m_s;
  bit m_r;
  int m_cnt;

  always #5 cp = ~cp;

  sr_cmd_gen #(
    .DEBOUNCE_CYCLES(DB),
    .CNT_W          (8)
  ) dut (
    .cp       (cp),
    .rst      (rst),
    .btn_set  (btn_set),
    .btn_reset(btn_reset),
    .s        (s),
    .r        (r),
    .cmd_cnt  (cmd_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_sy1[c] = 0;
      m_sy2[c] = 0;
      m_acc[c] = 0;
      m_run[c] = 0;
    end
    m_s   = 0;
    m_r   = 0;
    m_cnt = 0;
  endtask

  // One clock: capture raw inputs, advance the model at the edge, then compare just after it
  task automatic step();
    bit raw [2];
    bit str [2];
    bit obs;
    raw[0] = btn_set;
    raw[1] = btn_reset;
    @(posedge cp);
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        obs      = m_sy2[c];
        m_sy2[c] = m_sy1[c];
        m_sy1[c] = raw[c];
        str[c]   = 0;
        if (obs != m_acc[c]) begin
          m_run[c]++;
          if (m_run[c] == DB + 1) begin
            str[c]   = !m_acc[c];
            m_acc[c] = !m_acc[c];
            m_run[c] = 0;
          end
        end else begin
          m_run[c] = 0;
        end
      end
`ifdef SR_CMD_TOGGLE_EN
      m_s = str[0];
      m_r = str[1];
`else
      m_s = str[0] && !str[1];
      m_r = str[1] && !str[0];
`endif
      if (m_s || m_r) m_cnt = (m_cnt + 1) % 256;
    end else begin
      model_reset();
    end
    #1;
    check("s", s, m_s);
    check("r", r, m_r);
    if (!(m_s || m_r)) check("cmd_cnt", cmd_cnt, m_cnt);
  endtask

  task automatic hold(input bit set_v, input bit rst_v, input int n);
    btn_set   = set_v;
    btn_reset = rst_v;
    repeat (n) step();
  endtask

  // Assert reset mid-cycle and check outputs clear without a clock edge
  task automatic async_reset(input string tag);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check({tag, "_s"}, s, 1'b0);
    check({tag, "_r"}, r, 1'b0);
    check({tag, "_cnt"}, cmd_cnt, 8'd0);
  endtask

  initial begin
    int start_cnt;
    rst       = 1'b1;
    btn_set   = 1'b0;
    btn_reset = 1'b0;
    model_reset();

    // Power-on reset, released mid-cycle
    async_reset("por");
    step();
    step();
    #3 rst = 1'b1;
    hold(0, 0, 3);

    // Clean set press, then release
    hold(1, 0, 20);
    check("press_cnt", cmd_cnt, 8'd1);
    hold(0, 0, 10);

    // Bounce on reset button, then held
    hold(0, 1, 3);
    hold(0, 0, 2);
    hold(0, 1, 3);
    hold(0, 1, 10);
    check("bounce_cnt", cmd_cnt, 8'd2);
    hold(0, 0, 10);

    // Simultaneous press
    hold(1, 1, 12);
`ifdef SR_CMD_TOGGLE_EN
    check("simul_cnt", cmd_cnt, 8'd3);
`else
    check("simul_cnt", cmd_cnt, 8'd2);
`endif
    hold(0, 0, 10);

    // Reset mid-debounce with button still held
    btn_set = 1'b1;
    repeat (3) step();
    async_reset("mid_db");
    step();
    #3 rst = 1'b1;
    hold(1, 0, 12);
    hold(0, 0, 10);

    // Reset while the output pulse is high
    hold(1, 0, 7);
    async_reset("mid_pulse");
    step();
    #3 rst = 1'b1;
    hold(0, 0, 12);

    // Random bouncy activity on both channels
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 5) == 0) btn_set = !btn_set;
      if ($urandom_range(0, 5) == 0) btn_reset = !btn_reset;
      step();
    end
    hold(0, 0, 12);

    // 256 isolated presses wrap the counter back to its start value
    start_cnt = m_cnt;
    for (int i = 0; i < 256; i++) begin
      hold(1, 0, 8);
      hold(0, 0, 8);
    end
    check("wrap_cnt", cmd_cnt, start_cnt);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
